// File: rtl/hier_fanin_collector.sv
// Round-robin fan-in of NUM_SRC child streams into one registered output stage.
// Each output beat carries its source index; completed output handshakes are counted.
module hier_fanin_collector #(
    parameter  int NUM_SRC = 5,
    parameter  int DATA_W  = 16,
    parameter  int CNT_W   = 8,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic [CNT_W-1:0]          beat_cnt,
    output logic                      busy
);

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;
    logic [SRC_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                load_en;
    logic                any_valid;
    logic                src_hs;
    logic                out_hs;
    logic [SRC_W-1:0]    grant;
    logic [SRC_W-1:0]    grant_high;
    logic [SRC_W-1:0]    grant_low;
    logic                high_found;

    assign load_en   = !out_valid_q || out_ready;
    assign any_valid = |src_valid;
    assign out_hs    = out_valid_q && out_ready;

    // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        grant_high = '0;
        grant_low  = '0;
        high_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                grant_low = SRC_W'(i);
                if (SRC_W'(i) > last_grant_q) begin
                    grant_high = SRC_W'(i);
                    high_found = 1'b1;
                end
            end
        end
        grant = high_found ? grant_high : grant_low;
    end

    always_comb begin
        src_ready = '0;
        if (!rst && load_en && any_valid) begin
            src_ready = NUM_SRC'(1) << grant;
        end
    end

    assign src_hs = |(src_valid & src_ready);

    // A new beat always replaces the held one, so a drain and a load in one cycle leave no bubble.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        if (src_hs) begin
            out_valid_d  = 1'b1;
            out_data_d   = src_data[int'(grant)*DATA_W +: DATA_W];
            out_src_d    = grant;
            last_grant_d = grant;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
        if (out_hs) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
            beat_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign beat_cnt  = beat_cnt_q;
    assign busy      = out_valid_q || any_valid;

endmodule
